// File: rtl/decode_stage_if.sv
// Decode-stage bus bundle: fetch slot, register-file read port, bypass sources
// from E/M/W, and the D/E pipeline register outputs.
interface decode_stage_if #(
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
);
  logic                 f_valid_i;
  logic [31:0]          f_instr_i;
  logic [WIDTH-1:0]     f_pc_i;
  logic [REG_WIDTH-1:0] d_rs1_o;
  logic [REG_WIDTH-1:0] d_rs2_o;
  logic [WIDTH-1:0]     reg_valA_i;
  logic [WIDTH-1:0]     reg_valB_i;
  logic [REG_WIDTH-1:0] e_fwd_rd_i;
  logic                 e_fwd_wen_i;
  logic                 e_is_load_i;
  logic [WIDTH-1:0]     e_valE_i;
  logic [REG_WIDTH-1:0] m_rd_i;
  logic                 m_wen_i;
  logic [WIDTH-1:0]     m_valM_i;
  logic [REG_WIDTH-1:0] w_rd_i;
  logic                 w_wen_i;
  logic [WIDTH-1:0]     w_valWB_i;
  logic                 flush_i;
  logic                 d_stall_o;
  logic                 e_valid_o;
  logic [WIDTH-1:0]     e_pc_o;
  logic [31:0]          e_instr_o;
  logic [WIDTH-1:0]     e_valA_o;
  logic [WIDTH-1:0]     e_valB_o;
  logic [REG_WIDTH-1:0] e_rd_o;

  modport master (
    output f_valid_i, f_instr_i, f_pc_i, reg_valA_i, reg_valB_i,
           e_fwd_rd_i, e_fwd_wen_i, e_is_load_i, e_valE_i,
           m_rd_i, m_wen_i, m_valM_i, w_rd_i, w_wen_i, w_valWB_i, flush_i,
    input  d_rs1_o, d_rs2_o, d_stall_o, e_valid_o, e_pc_o, e_instr_o,
           e_valA_o, e_valB_o, e_rd_o
  );

  modport slave (
    input  f_valid_i, f_instr_i, f_pc_i, reg_valA_i, reg_valB_i,
           e_fwd_rd_i, e_fwd_wen_i, e_is_load_i, e_valE_i,
           m_rd_i, m_wen_i, m_valM_i, w_rd_i, w_wen_i, w_valWB_i, flush_i,
    output d_rs1_o, d_rs2_o, d_stall_o, e_valid_o, e_pc_o, e_instr_o,
           e_valA_o, e_valB_o, e_rd_o
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: operand bypass from E/M/W, load-use stall detection and the
// D/E pipeline register.
module decode_stage #(
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);
  localparam logic [31:0] NOP = 32'h00000013;

  logic [REG_WIDTH-1:0] rs1, rs2, rd;
  logic [WIDTH-1:0]     op_a, op_b;
  logic                 e_ok, m_ok, w_ok;
  logic                 load_use, stall;

  logic                 e_valid_q;
  logic [WIDTH-1:0]     e_pc_q, e_val_a_q, e_val_b_q;
  logic [31:0]          e_instr_q;
  logic [REG_WIDTH-1:0] e_rd_q;

  assign rs1 = REG_WIDTH'(bus.f_instr_i[19:15]);
  assign rs2 = REG_WIDTH'(bus.f_instr_i[24:20]);
  assign rd  = REG_WIDTH'(bus.f_instr_i[11:7]);

  // A load in E has no data yet, so it is never a bypass source.
  assign e_ok = bus.e_fwd_wen_i && !bus.e_is_load_i && (bus.e_fwd_rd_i != '0);
  assign m_ok = bus.m_wen_i && (bus.m_rd_i != '0);
  assign w_ok = bus.w_wen_i && (bus.w_rd_i != '0);

  // Later assignments win, so ordering W, M, E gives E the highest priority.
  always_comb begin
    op_a = bus.reg_valA_i;
    if (w_ok && bus.w_rd_i == rs1)     op_a = bus.w_valWB_i;
    if (m_ok && bus.m_rd_i == rs1)     op_a = bus.m_valM_i;
    if (e_ok && bus.e_fwd_rd_i == rs1) op_a = bus.e_valE_i;
    if (rs1 == '0)                     op_a = '0;

    op_b = bus.reg_valB_i;
    if (w_ok && bus.w_rd_i == rs2)     op_b = bus.w_valWB_i;
    if (m_ok && bus.m_rd_i == rs2)     op_b = bus.m_valM_i;
    if (e_ok && bus.e_fwd_rd_i == rs2) op_b = bus.e_valE_i;
    if (rs2 == '0)                     op_b = '0;
  end

  assign load_use = bus.f_valid_i && bus.e_fwd_wen_i && bus.e_is_load_i &&
                    (bus.e_fwd_rd_i != '0) &&
                    ((bus.e_fwd_rd_i == rs1) || (bus.e_fwd_rd_i == rs2));
  assign stall    = load_use && !bus.flush_i && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid_q <= 1'b0;
      e_pc_q    <= '0;
      e_instr_q <= NOP;
      e_val_a_q <= '0;
      e_val_b_q <= '0;
      e_rd_q    <= '0;
    end else if (bus.flush_i || stall || !bus.f_valid_i) begin
      e_valid_q <= 1'b0;
      e_instr_q <= NOP;
      e_val_a_q <= '0;
      e_val_b_q <= '0;
      e_rd_q    <= '0;
    end else begin
      e_valid_q <= 1'b1;
      e_pc_q    <= bus.f_pc_i;
      e_instr_q <= bus.f_instr_i;
      e_val_a_q <= op_a;
      e_val_b_q <= op_b;
      e_rd_q    <= rd;
    end
  end

  assign bus.d_rs1_o   = rs1;
  assign bus.d_rs2_o   = rs2;
  assign bus.d_stall_o = stall;
  assign bus.e_valid_o = e_valid_q;
  assign bus.e_pc_o    = e_pc_q;
  assign bus.e_instr_o = e_instr_q;
  assign bus.e_valA_o  = e_val_a_q;
  assign bus.e_valB_o  = e_val_b_q;
  assign bus.e_rd_o    = e_rd_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal cases followed by random traffic,
// all checked against a behavioural model of the stage.
module tb_decode_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic        rst, valid, flush;
    logic [31:0] instr, pc, ra, rb;
    logic [4:0]  erd;
    logic        ewen, eload;
    logic [31:0] ve;
    logic [4:0]  mrd;
    logic        mwen;
    logic [31:0] vm;
    logic [4:0]  wrd;
    logic        wwen;
    logic [31:0] vw;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, instr, a, b;
    logic [4:0]  rd;
  } de_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  decode_stage_if #(.WIDTH(32), .REG_WIDTH(5)) bus ();

  decode_stage #(.WIDTH(32), .REG_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rst             = s.rst;
    bus.f_valid_i   = s.valid;
    bus.flush_i     = s.flush;
    bus.f_instr_i   = s.instr;
    bus.f_pc_i      = s.pc;
    bus.reg_valA_i  = s.ra;
    bus.reg_valB_i  = s.rb;
    bus.e_fwd_rd_i  = s.erd;
    bus.e_fwd_wen_i = s.ewen;
    bus.e_is_load_i = s.eload;
    bus.e_valE_i    = s.ve;
    bus.m_rd_i      = s.mrd;
    bus.m_wen_i     = s.mwen;
    bus.m_valM_i    = s.vm;
    bus.w_rd_i      = s.wrd;
    bus.w_wen_i     = s.wwen;
    bus.w_valWB_i   = s.vw;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, valid: 1'b0, flush: 1'b0, instr: NOP, pc: 32'h0, ra: 32'h0,
          rb: 32'h0, erd: 5'd0, ewen: 1'b0, eload: 1'b0, ve: 32'h0, mrd: 5'd0,
          mwen: 1'b0, vm: 32'h0, wrd: 5'd0, wwen: 1'b0, vw: 32'h0};
    return s;
  endfunction

  // Reference: walk the producers youngest-first and take the first live match.
  function automatic logic [31:0] model_operand(input logic [4:0] idx, input logic [31:0] rf);
    logic [4:0]  src_rd[3];
    logic        src_on[3];
    logic [31:0] src_val[3];
    src_rd  = '{bus.e_fwd_rd_i, bus.m_rd_i, bus.w_rd_i};
    src_on  = '{bus.e_fwd_wen_i && !bus.e_is_load_i, bus.m_wen_i, bus.w_wen_i};
    src_val = '{bus.e_valE_i, bus.m_valM_i, bus.w_valWB_i};
    if (idx == 5'd0) return 32'h0;
    for (int i = 0; i < 3; i++)
      if (src_on[i] && src_rd[i] == idx) return src_val[i];
    return rf;
  endfunction

  function automatic logic model_stall();
    logic [31:0] w;
    w = bus.f_instr_i;
    if (rst || bus.flush_i || !bus.f_valid_i) return 1'b0;
    if (!(bus.e_fwd_wen_i && bus.e_is_load_i) || bus.e_fwd_rd_i == 5'd0) return 1'b0;
    return (bus.e_fwd_rd_i == w[19:15]) || (bus.e_fwd_rd_i == w[24:20]);
  endfunction

  de_t  exp_de;
  logic model_ready = 1'b0;
  logic pc_known    = 1'b0;
  logic full        = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_de      <= '{valid: 1'b0, pc: 32'h0, instr: NOP, a: 32'h0, b: 32'h0, rd: 5'd0};
      model_ready <= 1'b1;
      pc_known    <= 1'b1;
      full        <= 1'b1;
    end else if (bus.flush_i || model_stall()) begin
      exp_de.valid <= 1'b0;
      exp_de.instr <= NOP;
      exp_de.a     <= 32'h0;
      exp_de.b     <= 32'h0;
      exp_de.rd    <= 5'd0;
      full         <= 1'b1;
    end else if (!bus.f_valid_i) begin
      exp_de.valid <= 1'b0;
      exp_de.rd    <= 5'd0;
      full         <= 1'b0;
      pc_known     <= 1'b0;
    end else begin
      exp_de <= '{valid: 1'b1, pc: bus.f_pc_i, instr: bus.f_instr_i,
                  a: model_operand(bus.f_instr_i[19:15], bus.reg_valA_i),
                  b: model_operand(bus.f_instr_i[24:20], bus.reg_valB_i),
                  rd: bus.f_instr_i[11:7]};
      full     <= 1'b1;
      pc_known <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("e_valid", {31'b0, bus.e_valid_o}, {31'b0, exp_de.valid});
      checkOutput("e_rd", {27'b0, bus.e_rd_o}, {27'b0, exp_de.rd});
      if (full) begin
        checkOutput("e_instr", bus.e_instr_o, exp_de.instr);
        checkOutput("e_valA", bus.e_valA_o, exp_de.a);
        checkOutput("e_valB", bus.e_valB_o, exp_de.b);
      end
      if (pc_known) checkOutput("e_pc", bus.e_pc_o, exp_de.pc);
      checkOutput("d_rs1", {27'b0, bus.d_rs1_o}, {27'b0, bus.f_instr_i[19:15]});
      checkOutput("d_rs2", {27'b0, bus.d_rs2_o}, {27'b0, bus.f_instr_i[24:20]});
      checkOutput("d_stall", {31'b0, bus.d_stall_o}, {31'b0, model_stall()});
    end
  end

  initial begin
    stim_t       s;
    logic [31:0] w;

    s = idle();
    s.rst = 1'b1;
    applyStimulus(s);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'b0, bus.e_valid_o}, 32'h0);
    checkOutput("rst_instr", bus.e_instr_o, 32'h00000013);
    checkOutput("rst_pc", bus.e_pc_o, 32'h0);
    checkOutput("rst_stall", {31'b0, bus.d_stall_o}, 32'h0);

    // add x3,x1,x2 with no bypass matches
    s = idle();
    s.valid = 1'b1; s.instr = 32'h002081B3; s.pc = 32'h100; s.ra = 32'd5; s.rb = 32'd7;
    applyStimulus(s);
    @(posedge clk); #1;
    checkOutput("add_valA", bus.e_valA_o, 32'd5);
    checkOutput("add_valB", bus.e_valB_o, 32'd7);
    checkOutput("add_rd", {27'b0, bus.e_rd_o}, 32'd3);
    checkOutput("add_valid", {31'b0, bus.e_valid_o}, 32'd1);
    checkOutput("add_pc", bus.e_pc_o, 32'h100);

    // addi x6,x4,0 with x4 produced by E, M and W at once
    s.instr = 32'h00020313; s.ra = 32'h44;
    s.erd = 5'd4; s.ewen = 1'b1; s.ve = 32'h11;
    s.mrd = 5'd4; s.mwen = 1'b1; s.vm = 32'h22;
    s.wrd = 5'd4; s.wwen = 1'b1; s.vw = 32'h33;
    applyStimulus(s);
    @(posedge clk); #1;
    checkOutput("prio_E", bus.e_valA_o, 32'h11);
    s.ewen = 1'b0;
    applyStimulus(s);
    @(posedge clk); #1;
    checkOutput("prio_M", bus.e_valA_o, 32'h22);
    s.mwen = 1'b0;
    applyStimulus(s);
    @(posedge clk); #1;
    checkOutput("prio_W", bus.e_valA_o, 32'h33);

    // load-use on x5, then the load result arrives from M
    s = idle();
    s.valid = 1'b1; s.instr = 32'h000283B3; s.pc = 32'h104; s.ra = 32'h1;
    s.erd = 5'd5; s.ewen = 1'b1; s.eload = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("lu_stall", {31'b0, bus.d_stall_o}, 32'd1);
    @(posedge clk); #1;
    checkOutput("lu_bubble_valid", {31'b0, bus.e_valid_o}, 32'd0);
    checkOutput("lu_bubble_instr", bus.e_instr_o, 32'h00000013);
    s.erd = 5'd0; s.ewen = 1'b0; s.eload = 1'b0;
    s.mrd = 5'd5; s.mwen = 1'b1; s.vm = 32'h99;
    applyStimulus(s);
    #1;
    checkOutput("lu_release_stall", {31'b0, bus.d_stall_o}, 32'd0);
    @(posedge clk); #1;
    checkOutput("lu_release_valA", bus.e_valA_o, 32'h99);
    checkOutput("lu_release_valid", {31'b0, bus.e_valid_o}, 32'd1);

    // load-use coinciding with a flush
    s = idle();
    s.valid = 1'b1; s.instr = 32'h000283B3; s.flush = 1'b1;
    s.erd = 5'd5; s.ewen = 1'b1; s.eload = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("flush_stall", {31'b0, bus.d_stall_o}, 32'd0);
    @(posedge clk); #1;
    checkOutput("flush_valid", {31'b0, bus.e_valid_o}, 32'd0);
    checkOutput("flush_instr", bus.e_instr_o, 32'h00000013);

    // W writing x0 must not leak into a read of x0
    s = idle();
    s.valid = 1'b1; s.instr = 32'h00000093; s.pc = 32'h200; s.ra = 32'h0;
    s.wrd = 5'd0; s.wwen = 1'b1; s.vw = 32'hFFFF;
    applyStimulus(s);
    @(posedge clk); #1;
    checkOutput("x0_valA", bus.e_valA_o, 32'h0);
    checkOutput("x0_rd", {27'b0, bus.e_rd_o}, 32'd1);

    // reset mid-stream over a valid instruction that would otherwise stall
    s = idle();
    s.rst = 1'b1; s.valid = 1'b1; s.instr = 32'h002081B3; s.pc = 32'h300;
    s.ra = 32'h5; s.rb = 32'h7; s.erd = 5'd1; s.ewen = 1'b1; s.eload = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("rst_mid_stall", {31'b0, bus.d_stall_o}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_mid_valid", {31'b0, bus.e_valid_o}, 32'd0);
    checkOutput("rst_mid_pc", bus.e_pc_o, 32'h0);
    checkOutput("rst_mid_instr", bus.e_instr_o, 32'h00000013);
    checkOutput("rst_mid_valA", bus.e_valA_o, 32'h0);
    checkOutput("rst_mid_valB", bus.e_valB_o, 32'h0);
    checkOutput("rst_mid_rd", {27'b0, bus.e_rd_o}, 32'd0);

    // Small register indices so bypass matches and load-use hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 49) == 0);
      s.valid = ($urandom_range(0, 4) != 0);
      s.flush = ($urandom_range(0, 9) == 0);
      w = $urandom;
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      w[11:7]  = 5'($urandom_range(0, 7));
      s.instr = w;
      s.pc    = $urandom;
      s.ra    = $urandom;
      s.rb    = $urandom;
      s.erd   = 5'($urandom_range(0, 7));
      s.ewen  = 1'($urandom_range(0, 1));
      s.eload = ($urandom_range(0, 2) == 0);
      s.ve    = $urandom;
      s.mrd   = 5'($urandom_range(0, 7));
      s.mwen  = 1'($urandom_range(0, 1));
      s.vm    = $urandom;
      s.wrd   = 5'($urandom_range(0, 7));
      s.wwen  = 1'($urandom_range(0, 1));
      s.vw    = $urandom;
      applyStimulus(s);
      @(posedge clk); #1;
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Parameters
REQ-001 SHALL provide parameter WIDTH, default 32, data path width.
REQ-002 SHALL provide parameter REG_WIDTH, default 5, register index width.

Interface
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port f_valid_i  input  1  fetch/decode slot holds a valid instruction.
REQ-006 SHALL have port f_instr_i  input  32  instruction word from fetch.
REQ-007 SHALL have port f_pc_i  input  WIDTH  PC of f_instr_i.
REQ-008 SHALL have ports d_rs1_o, d_rs2_o  output  REG_WIDTH  read indices to register file.
REQ-009 SHALL have ports reg_valA_i, reg_valB_i  input  WIDTH  register file read data (index 0 reads 0).
REQ-010 SHALL have ports e_fwd_rd_i (REG_WIDTH), e_fwd_wen_i (1), e_is_load_i (1), e_valE_i (WIDTH)  input  execute-stage result.
REQ-011 SHALL have ports m_rd_i (REG_WIDTH), m_wen_i (1), m_valM_i (WIDTH)  input  memory-stage result.
REQ-012 SHALL have ports w_rd_i (REG_WIDTH), w_wen_i (1), w_valWB_i (WIDTH)  input  writeback result (same values driven to register file).
REQ-013 SHALL have port flush_i  input  1  execute redirect; squash decode slot.
REQ-014 SHALL have port d_stall_o  output  1  hold fetch and decode slot this cycle.
REQ-015 SHALL have ports e_valid_o (1), e_pc_o (WIDTH), e_instr_o (32), e_valA_o (WIDTH), e_valB_o (WIDTH), e_rd_o (REG_WIDTH)  output  D/E pipeline register.

Function
REQ-016 SHALL drive d_rs1_o=f_instr_i[19:15], d_rs2_o=f_instr_i[24:20] combinationally; rd=f_instr_i[11:7].
REQ-017 SHALL select operand A per source: index 0 -> 0; else E match (e_fwd_wen_i, not load) -> e_valE_i; else M match -> m_valM_i; else W match -> w_valWB_i; else reg_valA_i; operand B identical on rs2.
REQ-018 SHALL give priority E > M > W > register file when several stages match the same index.
REQ-019 SHALL never forward from a stage whose rd is 0 or whose wen is 0.
REQ-020 SHALL assert d_stall_o when f_valid_i & e_fwd_wen_i & e_is_load_i & e_fwd_rd_i!=0 & (e_fwd_rd_i==rs1 | e_fwd_rd_i==rs2); both sources treated as used for every opcode.
REQ-021 SHALL force d_stall_o=0 when flush_i=1.
REQ-022 SHALL, on posedge with no rst/flush/stall, load D/E register: e_valid_o<=f_valid_i, e_pc_o<=f_pc_i, e_instr_o<=f_instr_i, e_valA_o/e_valB_o<=forwarded operands, e_rd_o<=rd; latency exactly 1 cycle.
REQ-023 SHALL, on posedge with flush_i=1 or d_stall_o=1, load a bubble: e_valid_o=0, e_instr_o=32'h00000013, e_rd_o=0, e_valA_o=e_valB_o=0, e_pc_o unchanged.
REQ-024 SHALL load a bubble when f_valid_i=0 (e_valid_o=0, e_rd_o=0).
REQ-025 SHALL re-evaluate forwarding every cycle during a stall so the released instruction captures the loaded value from M.

Reset
REQ-026 SHALL, on posedge with rst=1, set e_valid_o=0, e_pc_o=0, e_instr_o=32'h00000013, e_valA_o=0, e_valB_o=0, e_rd_o=0; rst overrides flush_i and stall.
REQ-027 SHALL drive d_stall_o=0 while rst=1.

Verification
REQ-028 SHALL pass: add x3,x1,x2 with reg_valA_i=5, reg_valB_i=7, no matches -> next cycle e_valA_o=5, e_valB_o=7, e_rd_o=3, e_valid_o=1.
REQ-029 SHALL pass: rs1=x4 matched by E (valE=0x11), M (0x22), W (0x33) -> e_valA_o=0x11; drop E -> 0x22; drop M -> 0x33.
REQ-030 SHALL pass: lw x5 in E, decode uses x5 -> d_stall_o=1 one cycle, bubble (e_valid_o=0, e_instr_o=0x13); next cycle M forwards 0x99 -> e_valA_o=0x99, e_valid_o=1.
REQ-031 SHALL pass: load-use stall with flush_i=1 same cycle -> d_stall_o=0, bubble loaded.
REQ-032 SHALL pass: W writes x0 with 0xFFFF, decode reads x0 -> e_valA_o=0.
REQ-033 SHALL pass: rst asserted mid-stream with valid instruction -> next cycle all E outputs at reset values, d_stall_o=0.
